cache_mem_arbiter: RTL and testbench

Sequences and shares the single main-memory port between the instruction cache and the data cache. Each cache's memory-side interface (miss/write request, block base address, data-valid return with tagged address) connects here. The block serialises requests and drives 8-word block fills and 8-word block writes into a fixed-latency, in-order, pipelined memory. It sits between `cache_temp` instances and the memory model. The D-cache has priority.

---
 rtl/cache_mem_arbiter_if.sv | 42 ++++
 rtl/cache_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side signal bundle for the I/D cache memory arbiter.
interface cache_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  // I-cache side
  logic                  i_miss;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [ADDR_WIDTH-1:0] i_addr_out;
  logic                  i_valid;
  // D-cache side
  logic                  d_miss;
  logic                  d_wr;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_data;
  logic [ADDR_WIDTH-1:0] d_addr_out;
  logic                  d_valid;
  logic                  d_wgrant;
  // memory port
  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  // arbiter view
  modport master (
    input  i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output i_data, i_addr_out, i_valid, d_data, d_addr_out, d_valid, d_wgrant,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  // caches + memory view
  modport slave (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  i_data, i_addr_out, i_valid, d_data, d_addr_out, d_valid, d_wgrant,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one pipelined, in-order memory port between the I-cache and D-cache:
// serialises 8-word block fills (both sides) and 8-word block writes (D side).
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned WORDS       = 8,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_mem_arbiter_if.master  bus
);

  localparam int unsigned AW          = ADDR_WIDTH;
  localparam int unsigned CNT_W       = $clog2(WORDS) + 1;
  localparam int unsigned BLOCK_BYTES = WORDS * 2;

  // Memory latency only shapes the return timing; the arbiter just counts returns.
  if (MEM_LATENCY < 1 || WORDS < 2) begin : g_bad_params
    $error("cache_mem_arbiter: MEM_LATENCY must be >= 1 and WORDS >= 2");
  end

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE_D} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [CNT_W-1:0] rcv_q, rcv_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    raddr_q, raddr_d;

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(BLOCK_BYTES - 1);
  endfunction

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iss_q   <= '0;
      rcv_q   <= '0;
      wcnt_q  <= '0;
      base_q  <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
      wcnt_q  <= wcnt_d;
      base_q  <= base_d;
      raddr_q <= raddr_d;
    end
  end

  // Arbitration, read issue/return routing and write pass-through
  always_comb begin
    state_d        = state_q;
    iss_d          = iss_q;
    rcv_d          = rcv_q;
    wcnt_d         = wcnt_q;
    base_d         = base_q;
    raddr_d        = raddr_q;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.d_wgrant   = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_data     = '0;
    bus.i_addr_out = '0;
    bus.d_valid    = 1'b0;
    bus.d_data     = '0;
    bus.d_addr_out = '0;

    case (state_q)
      IDLE: begin
        iss_d  = '0;
        rcv_d  = '0;
        wcnt_d = '0;
        if (bus.d_miss) begin
          state_d = FILL_D;
          base_d  = align(bus.d_addr);
          raddr_d = align(bus.d_addr);
        end else if (bus.d_wr) begin
          state_d = WRITE_D;
        end else if (bus.i_miss) begin
          state_d = FILL_I;
          base_d  = align(bus.i_addr);
          raddr_d = align(bus.i_addr);
        end
      end

      FILL_I, FILL_D: begin
        if (iss_q < CNT_W'(WORDS)) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base_q + AW'({iss_q, 1'b0});
          iss_d        = iss_q + CNT_W'(1);
        end
        if (bus.mem_valid) begin
          if (state_q == FILL_I) begin
            bus.i_valid    = 1'b1;
            bus.i_data     = bus.mem_rdata;
            bus.i_addr_out = raddr_q;
          end else begin
            bus.d_valid    = 1'b1;
            bus.d_data     = bus.mem_rdata;
            bus.d_addr_out = raddr_q;
          end
          raddr_d = raddr_q + AW'(2);
          rcv_d   = rcv_q + CNT_W'(1);
          if (rcv_q == CNT_W'(WORDS - 1)) state_d = IDLE;
        end
      end

      WRITE_D: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_wgrant  = 1'b1;
        wcnt_d        = wcnt_q + CNT_W'(1);
        if (wcnt_q == CNT_W'(WORDS - 1)) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: transaction-timeline model plus literal spot checks.
module tb_cache_mem_arbiter;

  localparam int L = 4;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  cache_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus();

  cache_mem_arbiter #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .WORDS(8), .MEM_LATENCY(L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // cycle n is the interval after the n-th rising edge
  initial begin
    forever begin
      #5; cyc++; clk = 1'b1;
      #5; clk = 1'b0;
    end
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // ---------------- memory model: fixed latency, in order ----------------
  bit          ret_v   [N];
  logic [15:0] ret_a   [N];
  bit          stray_at[N];

  always @(negedge clk) begin
    if (bus.mem_en && !bus.mem_wr && (cyc + L < N)) begin
      ret_v[cyc + L] = 1'b1;
      ret_a[cyc + L] = bus.mem_addr;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.mem_valid = ret_v[cyc] | stray_at[cyc];
    bus.mem_rdata = ret_v[cyc] ? memf(ret_a[cyc]) : (stray_at[cyc] ? 16'hDEAD : 16'h0000);
  end

  // ---------------- reference model: per-cycle expected timeline ----------------
  bit          e_en[N], e_wr[N], e_gnt[N], e_iv[N], e_dv[N];
  logic [15:0] e_addr[N], e_wdata[N], e_xaddr[N], e_xdata[N];
  int          busy_until = -1;
  int          mn;

  localparam logic [15:0] WBASE = 16'h2000;
  localparam logic [15:0] WDAT0 = 16'hA000;

  task automatic sched_fill(input bit is_i, input logic [15:0] base, input int c);
    for (int k = 0; k < 8; k++) begin
      e_en[c + 1 + k]   = 1'b1;
      e_wr[c + 1 + k]   = 1'b0;
      e_addr[c + 1 + k] = base + 16'(2 * k);
      if (is_i) e_iv[c + 1 + L + k] = 1'b1;
      else      e_dv[c + 1 + L + k] = 1'b1;
      e_xaddr[c + 1 + L + k] = base + 16'(2 * k);
      e_xdata[c + 1 + L + k] = memf(base + 16'(2 * k));
    end
    busy_until = c + 8 + L;
  endtask

  task automatic sched_write(input int c);
    for (int k = 0; k < 8; k++) begin
      e_en[c + 1 + k]    = 1'b1;
      e_wr[c + 1 + k]    = 1'b1;
      e_gnt[c + 1 + k]   = 1'b1;
      e_addr[c + 1 + k]  = WBASE + 16'(2 * k);
      e_wdata[c + 1 + k] = WDAT0 + 16'(k);
    end
    busy_until = c + 8;
  endtask

  // Compare DUT against the timeline every cycle, then let the model arbitrate
  always @(negedge clk) begin
    mn = cyc;
    if (!rst) begin
      for (int k = mn; k < N; k++) begin
        e_en[k] = 1'b0; e_wr[k] = 1'b0; e_gnt[k] = 1'b0; e_iv[k] = 1'b0; e_dv[k] = 1'b0;
      end
      busy_until = mn;
    end
    chk1 ("mem_en",   bus.mem_en,   e_en[mn]);
    chk1 ("mem_wr",   bus.mem_wr,   e_en[mn] && e_wr[mn]);
    chk16("mem_addr", bus.mem_addr, e_en[mn] ? e_addr[mn] : 16'h0000);
    if (!e_en[mn] || e_wr[mn])
      chk16("mem_wdata", bus.mem_wdata, e_en[mn] ? e_wdata[mn] : 16'h0000);
    chk1("d_wgrant", bus.d_wgrant, e_gnt[mn]);
    chk1("i_valid",  bus.i_valid,  e_iv[mn]);
    chk1("d_valid",  bus.d_valid,  e_dv[mn]);
    if (e_iv[mn] || !rst) begin
      chk16("i_data",     bus.i_data,     e_iv[mn] ? e_xdata[mn] : 16'h0000);
      chk16("i_addr_out", bus.i_addr_out, e_iv[mn] ? e_xaddr[mn] : 16'h0000);
    end
    if (e_dv[mn] || !rst) begin
      chk16("d_data",     bus.d_data,     e_dv[mn] ? e_xdata[mn] : 16'h0000);
      chk16("d_addr_out", bus.d_addr_out, e_dv[mn] ? e_xaddr[mn] : 16'h0000);
    end
    if (rst && mn > busy_until && mn + 20 < N) begin
      if (bus.d_miss)      sched_fill(1'b0, bus.d_addr & 16'hFFF0, mn);
      else if (bus.d_wr)   sched_write(mn);
      else if (bus.i_miss) sched_fill(1'b1, bus.i_addr & 16'hFFF0, mn);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic goto(input int k);
    while (cyc < k) @(posedge clk);
    #2;
  endtask

  task automatic at_neg(input int k);
    while (cyc < k) @(posedge clk);
    @(negedge clk);
  endtask

  int r;

  initial begin
    rst = 1'b0;
    bus.i_miss = 1'b0; bus.i_addr = 16'h0;
    bus.d_miss = 1'b0; bus.d_wr = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;

    at_neg(1);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_i_valid", bus.i_valid, 1'b0);
    goto(3); rst = 1'b1;

    // I fill of 0x1234; miss dropped after sampling (no abort)
    r = 5;
    goto(r); bus.i_addr = 16'h1234; bus.i_miss = 1'b1;
    goto(r + 1); bus.i_miss = 1'b0;
    at_neg(r + 1);  chk16("t1_first_addr", bus.mem_addr, 16'h1230);
                    chk1 ("t1_first_en", bus.mem_en, 1'b1);
    at_neg(r + 5);  chk1 ("t1_first_ival", bus.i_valid, 1'b1);
                    chk16("t1_first_iaddr", bus.i_addr_out, 16'h1230);
                    chk16("t1_first_idata", bus.i_data, 16'hD195);
                    chk1 ("t1_no_dval", bus.d_valid, 1'b0);
    at_neg(r + 8);  chk16("t1_last_addr", bus.mem_addr, 16'h123E);
    at_neg(r + 12); chk16("t1_last_iaddr", bus.i_addr_out, 16'h123E);
    at_neg(r + 13); chk1 ("t1_idle_en", bus.mem_en, 1'b0);
                    chk1 ("t1_idle_ival", bus.i_valid, 1'b0);

    // D and I miss together: D first, I starts after D returns to IDLE
    r = 20;
    stray_at[r + 27] = 1'b1;
    goto(r); bus.d_addr = 16'h8F0A; bus.d_miss = 1'b1; bus.i_addr = 16'h0040; bus.i_miss = 1'b1;
    goto(r + 1); bus.d_miss = 1'b0;
    at_neg(r + 1);  chk16("t2_d_addr", bus.mem_addr, 16'h8F00);
    at_neg(r + 5);  chk1 ("t2_dval", bus.d_valid, 1'b1);
                    chk16("t2_daddr_out", bus.d_addr_out, 16'h8F00);
                    chk1 ("t2_no_ival", bus.i_valid, 1'b0);
    at_neg(r + 13); chk1 ("t2_gap_en", bus.mem_en, 1'b0);
    goto(r + 14); bus.i_miss = 1'b0;
    at_neg(r + 14); chk16("t2_i_addr", bus.mem_addr, 16'h0040);
    at_neg(r + 18); chk1 ("t2_ival", bus.i_valid, 1'b1);
                    chk16("t2_idata", bus.i_data, 16'hC3E5);
    at_neg(r + 27); chk1 ("t2_stray_ival", bus.i_valid, 1'b0);
                    chk1 ("t2_stray_dval", bus.d_valid, 1'b0);

    // D block write, with a stray mem_valid in the middle
    r = 50;
    stray_at[r + 3] = 1'b1;
    goto(r); bus.d_addr = WBASE; bus.d_wdata = WDAT0; bus.d_wr = 1'b1;
    goto(r + 1); bus.d_wr = 1'b0;
    for (int k = 1; k < 8; k++) begin
      goto(r + 1 + k);
      bus.d_addr  = WBASE + 16'(2 * k);
      bus.d_wdata = WDAT0 + 16'(k);
    end
    at_neg(r + 8);  chk16("t3_last_addr", bus.mem_addr, 16'h200E);
                    chk16("t3_last_wdata", bus.mem_wdata, 16'hA007);
                    chk1 ("t3_last_gnt", bus.d_wgrant, 1'b1);
    at_neg(r + 9);  chk1 ("t3_gnt_off", bus.d_wgrant, 1'b0);

    // Top-of-memory block: no wrap
    r = 62;
    goto(r); bus.i_addr = 16'hFFF6; bus.i_miss = 1'b1;
    goto(r + 1); bus.i_miss = 1'b0;
    at_neg(r + 1);  chk16("t4_first_addr", bus.mem_addr, 16'hFFF0);
    at_neg(r + 8);  chk16("t4_last_addr", bus.mem_addr, 16'hFFFE);
    at_neg(r + 12); chk16("t4_last_iaddr", bus.i_addr_out, 16'hFFFE);

    // Reset in the middle of an I fill; late returns land in IDLE
    r = 77;
    goto(r); bus.i_addr = 16'h0100; bus.i_miss = 1'b1;
    goto(r + 6); rst = 1'b0;
    at_neg(r + 6);  chk1 ("t5_rst_en", bus.mem_en, 1'b0);
                    chk1 ("t5_rst_ival", bus.i_valid, 1'b0);
                    chk16("t5_rst_addr", bus.mem_addr, 16'h0000);
    goto(r + 7); rst = 1'b1; bus.i_miss = 1'b0;
    at_neg(r + 7);  chk1 ("t5_late_ival", bus.i_valid, 1'b0);
    goto(r + 10); bus.i_addr = 16'h0200; bus.i_miss = 1'b1;
    goto(r + 11); bus.i_miss = 1'b0;
    at_neg(r + 11); chk16("t5_new_addr", bus.mem_addr, 16'h0200);
    at_neg(r + 15); chk1 ("t5_new_ival", bus.i_valid, 1'b1);
                    chk16("t5_new_iaddr", bus.i_addr_out, 16'h0200);
                    chk16("t5_new_idata", bus.i_data, 16'hC1A5);
    at_neg(r + 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
